// File: rtl/anchor_cmd_sched.sv
// anchor_cmd_sched: queues add/delete anchor commands, buffers add features and drives the Updater strobes.
module anchor_cmd_sched #(
  parameter int DATA_BUS_WIDTH    = 64,
  parameter int FEATURE_LENTH     = 9,
  parameter int LOG_CHILD_NUM     = 3,
  parameter int TREE_LEVEL        = 5,
  parameter int LOG_TREE_LEVEL    = 3,
  parameter int ENCODE_ADDR_WIDTH = LOG_CHILD_NUM*TREE_LEVEL+LOG_TREE_LEVEL,
  parameter int CMD_DEPTH         = 4,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_op,
  input  logic [ENCODE_ADDR_WIDTH-1:0] cmd_pos,
  input  logic                         feat_valid,
  output logic                         feat_ready,
  input  logic [DATA_BUS_WIDTH-1:0]    feat_data,
  output logic                         add_anchor,
  output logic                         del_anchor,
  output logic [ENCODE_ADDR_WIDTH-1:0] pos_encode,
  output logic [DATA_BUS_WIDTH-1:0]    feature_in,
  input  logic                         add_done,
  input  logic                         del_done,
  output logic                         busy,
  output logic                         err_bad_level,
  output logic                         err_timeout,
  output logic [15:0]                  done_cnt
);
  localparam int AW = $clog2(CMD_DEPTH);
  localparam int KW = $clog2(FEATURE_LENTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE_ADD, WAIT_ADD, ISSUE_DEL, WAIT_DEL} state_t;
  state_t state, state_n;
  logic [ENCODE_ADDR_WIDTH:0] fifo [CMD_DEPTH];
  logic [DATA_BUS_WIDTH-1:0] fbuf [FEATURE_LENTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [KW-1:0] beat;
  logic [TW-1:0] timer;
  logic [DATA_BUS_WIDTH-1:0] feat_last;
  logic [ENCODE_ADDR_WIDTH:0] head;
  logic empty, full, push, pop, bad, feat_acc, last_beat, waiting, match_done;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head = fifo[rd_ptr[AW-1:0]];
  assign push = cmd_valid && cmd_ready;
  assign pop = state == IDLE && !empty;
  assign bad = head[ENCODE_ADDR_WIDTH-1 -: LOG_TREE_LEVEL] >= LOG_TREE_LEVEL'(TREE_LEVEL);
  assign feat_acc = state == LOAD && feat_valid;
  assign last_beat = beat == KW'(FEATURE_LENTH-1);
  assign waiting = state == WAIT_ADD || state == WAIT_DEL;
  assign match_done = (state == WAIT_ADD && add_done) || (state == WAIT_DEL && del_done);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (pop) state_n = bad ? IDLE : head[ENCODE_ADDR_WIDTH] ? ISSUE_DEL : LOAD;
      LOAD:      if (feat_acc && last_beat) state_n = ISSUE_ADD;
      ISSUE_ADD: if (last_beat) state_n = WAIT_ADD;
      ISSUE_DEL: state_n = WAIT_DEL;
      WAIT_ADD, WAIT_DEL: if (match_done || timer == TW'(TIMEOUT_CYCLES-1)) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
    cmd_ready = !full && !rst;
    feat_ready = state == LOAD;
    add_anchor = state == ISSUE_ADD && beat == '0;
    del_anchor = state == ISSUE_DEL;
    feature_in = state == ISSUE_ADD ? fbuf[beat] : feat_last;
    busy = state != IDLE || !empty;
    err_bad_level = pop && bad;
    err_timeout = waiting && !match_done && timer == TW'(TIMEOUT_CYCLES-1);
  end
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr[AW-1:0]] <= {cmd_op, cmd_pos};
    if (feat_acc) fbuf[beat] <= feat_data;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      beat       <= '0;
      timer      <= '0;
      feat_last  <= '0;
      pos_encode <= '0;
      done_cnt   <= '0;
    end else begin
      state <= state_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (pop) pos_encode <= head[ENCODE_ADDR_WIDTH-1:0];
      // beat doubles as the burst index k and restarts on every state change
      beat <= state_n != state ? '0 : (feat_acc || state == ISSUE_ADD) ? beat + 1'b1 : beat;
      timer <= state_n != state ? '0 : waiting ? timer + 1'b1 : timer;
      if (state == ISSUE_ADD) feat_last <= fbuf[beat];
      if (match_done) done_cnt <= done_cnt + 1'b1;
    end
  end
endmodule
